reg_file_wr_arbiter: RTL and testbench
======================================

Name: reg_file_wr_arbiter

Overview:
- Shares the single write port of the register file between NUM_REQ requesters (CPU pipeline, DMA, debug, ...) using round-robin arbitration with a valid/ready handshake per requester.
- Contains a built-in clear sequencer that zeroes every register entry over consecutive cycles on command.
- Sits directly in front of the register file's write port (we / write_addr / write_data); read ports are untouched.

Parameters:
- NUM_REQ, 4, number of write requesters (>=2).
- DATA_WIDTH, 8, register data width.
- ADDR_WIDTH, 4, register address width.
- DEPTH, 1<<ADDR_WIDTH, number of register entries swept by clear.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester write request.
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_data  in  NUM_REQ*DATA_WIDTH  flattened data; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  one-hot grant, combinational from current state and req_valid.
- clr_start  in  1  request full clear of the register file.
- clr_busy  out  1  clear sweep in progress.
- clr_done  out  1  one-cycle pulse with the final clear write.
- rf_we  out  1  register file write enable (registered).
- rf_write_addr  out  ADDR_WIDTH  register file write address (registered).
- rf_write_data  out  DATA_WIDTH  register file write data (registered).
- rf_grant_id  out  $clog2(NUM_REQ)  requester that owns the current rf write; 0 for clear writes.

Behaviour:
- One clock, clk. Reset is asynchronous, active-low on rst_n.
- Reset values: state=ARB, rr_ptr=0, clr_cnt=0, rf_we=0, rf_write_addr=0, rf_write_data=0, rf_grant_id=0, clr_busy=0, clr_done=0.
- req_ready is 0 while rst_n is low.
- FSM has two states: ARB and CLEAR.
- ARB, clr_start=1: the FSM moves to CLEAR at the next edge with clr_cnt=0.
  - No grant is issued in that cycle; req_ready=0 everywhere. Clear has priority over simultaneous requests.
  - rf_we=0 at the next edge.
- ARB, clr_start=0:
  - The winner is the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[winner]=1; all other ready bits are 0.
  - A transfer occurs when req_valid[i] and req_ready[i] are both 1.
- On transfer, at the next edge: rf_we=1, rf_write_addr=req_addr[winner], rf_write_data=req_data[winner], rf_grant_id=winner, and rr_ptr=(winner+1) mod NUM_REQ.
- Latency is 1 cycle from handshake to rf_we. Throughput is one write per cycle, with no bubble between back-to-back grants.
- No valid request: rf_we=0 at the next edge and rr_ptr is held.
- Requester rules: a requester holds valid, addr and data stable until ready. A requester may drop valid before it is granted; no penalty and no state change.
- CLEAR: req_ready=0 for all requesters. At each edge, rf_we=1, rf_write_addr=clr_cnt, rf_write_data=0, rf_grant_id=0, and clr_cnt increments.
  - At the edge where clr_cnt=DEPTH-1: state returns to ARB, clr_cnt returns to 0, and clr_done=1 for exactly the cycle in which address DEPTH-1 is presented.
  - clr_start is ignored while in CLEAR.
- clr_busy=1 exactly while state=CLEAR, i.e. DEPTH cycles. The rf writes lag clr_busy by one cycle.
- clr_cnt wraps naturally at ADDR_WIDTH bits. DEPTH must equal 1<<ADDR_WIDTH.
- rr_ptr is unchanged by a clear.
- Asynchronous reset mid-operation (in either state) returns all state to reset values immediately. An in-flight registered write is dropped (rf_we=0). A partial clear is not resumed.
- The arbiter never resolves write collisions itself: exactly one rf write per cycle, by construction.

Test Plan:
- Reset/idle: hold rst_n=0 then release, all req_valid=0 for 5 cycles -> rf_we=0, req_ready=0, clr_busy=0 throughout.
- Single request: req_valid=4'b0100, addr=3, data=8'hA5 -> req_ready=4'b0100 the same cycle; next cycle rf_we=1, addr=3, data=A5, rf_grant_id=2; rr_ptr then 3.
- Round-robin fairness: all 4 valid continuously for 8 cycles from reset -> grants 0,1,2,3,0,1,2,3; rf_we high 8 consecutive cycles after a 1-cycle latency.
- Clear priority: clr_start=1 with req_valid=4'b1111 in the same cycle -> no ready that cycle.
  - clr_busy high for 16 cycles; rf writes to addr 0..15 with data 0; clr_done coincides with addr 15.
  - Grants resume at rr_ptr afterwards.
- Clear ignored: pulse clr_start again mid-sweep -> sweep still ends after exactly 16 writes, with a single clr_done pulse.
- Async reset mid-clear: assert rst_n=0 while clr_cnt=7, asynchronous to clk -> outputs are 0 immediately.
  - After release: state=ARB, and a request to addr 9 is granted normally.

Source files
------------

// File: rtl/reg_file_wr_arbiter_if.sv
// Write-side bus of the register file arbiter: requester handshakes, clear control, rf write port.
// master: requester/control side (drives req_*, clr_start); slave: the arbiter (drives req_ready, clr_*, rf_*).
// req_addr/req_data are flattened per requester: requester i at [i*W +: W].
interface reg_file_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          clr_start;
    logic                          clr_busy;
    logic                          clr_done;
    logic                          rf_we;
    logic [ADDR_WIDTH-1:0]         rf_write_addr;
    logic [DATA_WIDTH-1:0]         rf_write_data;
    logic [IDW-1:0]                rf_grant_id;

    modport master (
        output req_valid, req_addr, req_data, clr_start,
        input  req_ready, clr_busy, clr_done,
        input  rf_we, rf_write_addr, rf_write_data, rf_grant_id
    );

    modport slave (
        input  req_valid, req_addr, req_data, clr_start,
        output req_ready, clr_busy, clr_done,
        output rf_we, rf_write_addr, rf_write_data, rf_grant_id
    );
endinterface

// File: rtl/reg_file_wr_arbiter.sv
// Round-robin arbiter sharing the register file write port among NUM_REQ requesters, plus a clear sweep.
// Latency: 1 cycle from req handshake to registered rf write; one write per cycle, no bubbles.
// Backpressure: one-hot req_ready from current state; all ready low while clearing or when clr_start is seen.
// Ports: clk, rst_n (async active-low), bus (slave modport of reg_file_wr_arbiter_if).
module reg_file_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    reg_file_wr_arbiter_if.slave   bus
);
    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic {ARB, CLEAR} state_t;

    state_t                 state;
    logic [IDW-1:0]         rr_ptr;
    logic [ADDR_WIDTH-1:0]  clr_cnt;

    logic                   win_found;
    logic [IDW-1:0]         win_idx;
    logic [IDW-1:0]         cand;
    int unsigned            idx;
    logic                   arb_open;
    logic [NUM_REQ-1:0]     grant;
    logic                   xfer;
    logic [IDW-1:0]         next_ptr;

    // Scan rr_ptr, rr_ptr+1, ... (mod NUM_REQ) for the first valid requester.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ)
                idx = idx - NUM_REQ;
            cand = IDW'(idx);
            if (!win_found && bus.req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // A clear request takes the port this cycle, so no grant is offered alongside it.
    assign arb_open = rst_n && (state == ARB) && !bus.clr_start;

    always_comb begin
        grant          = '0;
        grant[win_idx] = win_found && arb_open;
    end

    assign bus.req_ready = grant;
    assign xfer          = |grant;
    assign next_ptr      = (win_idx == IDW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= ARB;
            rr_ptr            <= '0;
            clr_cnt           <= '0;
            bus.rf_we         <= 1'b0;
            bus.rf_write_addr <= '0;
            bus.rf_write_data <= '0;
            bus.rf_grant_id   <= '0;
            bus.clr_busy      <= 1'b0;
            bus.clr_done      <= 1'b0;
        end else begin
            bus.rf_we    <= 1'b0;
            bus.clr_done <= 1'b0;
            case (state)
                ARB: begin
                    if (bus.clr_start) begin
                        state        <= CLEAR;
                        bus.clr_busy <= 1'b1;
                        clr_cnt      <= '0;
                    end else if (xfer) begin
                        bus.rf_we         <= 1'b1;
                        bus.rf_write_addr <= bus.req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        bus.rf_write_data <= bus.req_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
                        bus.rf_grant_id   <= win_idx;
                        rr_ptr            <= next_ptr;
                    end
                end
                CLEAR: begin
                    // clr_start is deliberately not looked at here: a sweep always runs to completion.
                    bus.rf_we         <= 1'b1;
                    bus.rf_write_addr <= clr_cnt;
                    bus.rf_write_data <= '0;
                    bus.rf_grant_id   <= '0;
                    if (clr_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
                        state        <= ARB;
                        bus.clr_busy <= 1'b0;
                        bus.clr_done <= 1'b1;
                        clr_cnt      <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_file_wr_arbiter.sv
// Directed testbench for reg_file_wr_arbiter: reset, single grant, round-robin, clear, async reset.
// Inputs change 1 time unit after the rising edge; outputs are compared away from the edge.
// Every comparison goes through check(); a summary line closes the run.
module tb_reg_file_wr_arbiter;
    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 4;

    logic clk = 1'b0;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    reg_file_wr_arbiter_if #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) bus ();

    reg_file_wr_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (1 << ADDR_WIDTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] a, input logic [7:0] d);
        bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = a;
        bus.req_data[i*DATA_WIDTH +: DATA_WIDTH] = d;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.clr_start = 1'b0;

        // Reset state, and ready gated while reset is held.
        #2;
        check("rst_we", bus.rf_we, 0);
        check("rst_busy", bus.clr_busy, 0);
        check("rst_done", bus.clr_done, 0);
        check("rst_gid", bus.rf_grant_id, 0);
        bus.req_valid = 4'b1111;
        #1;
        check("rst_ready_gated", bus.req_ready, 0);
        bus.req_valid = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset.
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle_we", bus.rf_we, 0);
            check("idle_ready", bus.req_ready, 0);
            check("idle_busy", bus.clr_busy, 0);
        end

        // Single request from requester 2.
        set_req(2, 4'd3, 8'hA5);
        bus.req_valid = 4'b0100;
        #1;
        check("single_ready", bus.req_ready, 4'b0100);
        step();
        bus.req_valid = '0;
        check("single_we", bus.rf_we, 1);
        check("single_addr", bus.rf_write_addr, 3);
        check("single_data", bus.rf_write_data, 8'hA5);
        check("single_gid", bus.rf_grant_id, 2);

        // rr_ptr is now 3: with everyone valid, requester 3 wins first.
        for (int i = 0; i < NUM_REQ; i++)
            set_req(i, 4'(i + 4), 8'(8'h10 + i));
        bus.req_valid = 4'b1111;
        #1;
        check("ptr3_ready", bus.req_ready, 4'b1000);
        step();
        check("ptr3_gid", bus.rf_grant_id, 3);
        check("ptr3_data", bus.rf_write_data, 8'h13);

        // Round robin with everyone valid: 0,1,2,3,0,1,2,3 back to back.
        for (int i = 0; i < 8; i++) begin
            check("rr_ready", bus.req_ready, 32'(1) << (i % 4));
            step();
            check("rr_we", bus.rf_we, 1);
            check("rr_gid", bus.rf_grant_id, i % 4);
            check("rr_addr", bus.rf_write_addr, (i % 4) + 4);
            check("rr_data", bus.rf_write_data, 8'h10 + (i % 4));
        end

        // Clear with simultaneous requests: clear wins, no ready.
        bus.clr_start = 1'b1;
        #1;
        check("clr_prio_ready", bus.req_ready, 0);
        step();
        bus.clr_start = 1'b0;
        check("clr_enter_busy", bus.clr_busy, 1);
        check("clr_enter_we", bus.rf_we, 0);
        for (int k = 0; k < 16; k++) begin
            if (k == 5) bus.clr_start = 1'b1;  // ignored mid-sweep
            if (k == 6) bus.clr_start = 1'b0;
            #1;
            check("clr_ready", bus.req_ready, 0);
            step();
            check("clr_we", bus.rf_we, 1);
            check("clr_addr", bus.rf_write_addr, k);
            check("clr_data", bus.rf_write_data, 0);
            check("clr_gid", bus.rf_grant_id, 0);
            check("clr_done", bus.clr_done, (k == 15) ? 1 : 0);
            check("clr_busy", bus.clr_busy, (k == 15) ? 0 : 1);
        end

        // Grants resume at rr_ptr = 0.
        #1;
        check("resume_ready", bus.req_ready, 4'b0001);
        step();
        check("resume_gid", bus.rf_grant_id, 0);
        check("resume_addr", bus.rf_write_addr, 4);
        check("resume_done_low", bus.clr_done, 0);
        bus.req_valid = '0;
        step();
        check("resume_idle_we", bus.rf_we, 0);

        // Async reset while clr_cnt = 7.
        bus.clr_start = 1'b1;
        step();
        bus.clr_start = 1'b0;
        bus.req_valid = 4'b1111;
        repeat (7) step();
        check("pre_rst_addr", bus.rf_write_addr, 6);
        check("pre_rst_busy", bus.clr_busy, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_we", bus.rf_we, 0);
        check("arst_busy", bus.clr_busy, 0);
        check("arst_addr", bus.rf_write_addr, 0);
        check("arst_ready", bus.req_ready, 0);
        bus.req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst_we", bus.rf_we, 0);
        check("post_rst_busy", bus.clr_busy, 0);

        // Normal grant after reset.
        set_req(1, 4'd9, 8'h3C);
        bus.req_valid = 4'b0010;
        #1;
        check("post_rst_ready", bus.req_ready, 4'b0010);
        step();
        bus.req_valid = '0;
        check("post_rst_gwe", bus.rf_we, 1);
        check("post_rst_addr", bus.rf_write_addr, 9);
        check("post_rst_data", bus.rf_write_data, 8'h3C);
        check("post_rst_gid", bus.rf_grant_id, 1);
        step();
        check("final_idle_we", bus.rf_we, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
